// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Provides the fetch FSM state encoding, the NOP word and the instruction width.
package fetch_pkg;

    localparam int INSTR_W = 32;

    // addi x0, x0, 0
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        F_IDLE,
        F_REQ,
        F_WAIT,
        F_DONE
    } fetch_state_t;

endpackage

// File: rtl/fetch.sv
// Instruction fetch stage: issues one imem read per request, waits MEM_LATENCY
// cycles and presents pc/instr_raw to decode with an enabled/completed handshake.
//   clk, rst           : clock, synchronous active-high reset
//   enabled            : request next fetch (accepted only in IDLE/DONE)
//   branch_taken/target: redirect sampled with an accepted request
//   imem_en/addr/rdata : instruction memory read port
//   completed          : result valid (done & !enabled)
//   pc/instr_raw       : fetched address and word
//   misaligned         : fetch address not word aligned; instr_raw is NOP
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enabled,
    input  logic               branch_taken,
    input  logic [31:0]        branch_target,
    output logic               imem_en,
    output logic [31:0]        imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               completed,
    output logic [31:0]        pc,
    output logic [INSTR_W-1:0] instr_raw,
    output logic               misaligned
);

    localparam logic [2:0] LAT_INIT = 3'(MEM_LATENCY - 1);

    fetch_state_t state_q;
    fetch_state_t state_d;

    logic [31:0] pc_next_reg;
    logic [31:0] fetch_addr_q;
    logic [31:0] fetch_addr;
    logic [2:0]  count;
    logic        done;
    logic        accept;
    logic        capture;
    logic        addr_mis;

    assign fetch_addr = branch_taken ? branch_target : pc_next_reg;
    assign addr_mis   = |fetch_addr_q[1:0];
    assign completed  = done & ~enabled;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= F_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Requests arriving in REQ/WAIT are dropped, not queued.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            F_IDLE, F_DONE: begin
                if (enabled) begin
                    state_d = F_REQ;
                    accept  = 1'b1;
                end
            end
            F_REQ: begin
                state_d = F_WAIT;
            end
            F_WAIT: begin
                if (count == 3'd0) begin
                    state_d = F_DONE;
                    capture = 1'b1;
                end
            end
            default: begin
                state_d = F_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_next_reg  <= RESET_PC;
            fetch_addr_q <= RESET_PC;
            done         <= 1'b0;
            imem_en      <= 1'b0;
            imem_addr    <= 32'h0;
            pc           <= 32'h0;
            instr_raw    <= NOP_INSTR;
            misaligned   <= 1'b0;
            count        <= 3'd0;
        end else begin
            if (accept) begin
                fetch_addr_q <= fetch_addr;
                imem_addr    <= {fetch_addr[31:2], 2'b00};
                imem_en      <= 1'b1;
                done         <= 1'b0;
            end
            if (state_q == F_REQ) begin
                imem_en <= 1'b0;
                count   <= LAT_INIT;
            end
            if (state_q == F_WAIT && count != 3'd0) begin
                count <= count - 3'd1;
            end
            if (capture) begin
                // Misaligned fetches still read memory; the word is discarded.
                instr_raw   <= addr_mis ? NOP_INSTR : imem_rdata;
                pc          <= fetch_addr_q;
                misaligned  <= addr_mis;
                pc_next_reg <= fetch_addr_q + 32'd4;
                done        <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: one instance at MEM_LATENCY=1, one at 3,
// each fed by a behavioural pipelined instruction memory.
module tb_fetch;

    logic clk;
    int   total = 0;
    int   bad   = 0;

    logic        rst1, en1, bt1;
    logic [31:0] tgt1;
    logic        imem_en1;
    logic [31:0] imem_addr1, rdata1, pc1, instr1;
    logic        completed1, mis1;

    logic        rst3, en3, bt3;
    logic [31:0] tgt3;
    logic        imem_en3;
    logic [31:0] imem_addr3, rdata3, pc3, instr3;
    logic        completed3, mis3;

    logic [31:0] p1;
    logic [31:0] p3 [3];

    fetch #(.RESET_PC(32'h0), .MEM_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst1), .enabled(en1),
        .branch_taken(bt1), .branch_target(tgt1),
        .imem_en(imem_en1), .imem_addr(imem_addr1),
        .imem_rdata(rdata1), .completed(completed1),
        .pc(pc1), .instr_raw(instr1), .misaligned(mis1)
    );

    fetch #(.RESET_PC(32'h0), .MEM_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst3), .enabled(en3),
        .branch_taken(bt3), .branch_target(tgt3),
        .imem_en(imem_en3), .imem_addr(imem_addr3),
        .imem_rdata(rdata3), .completed(completed3),
        .pc(pc3), .instr_raw(instr3), .misaligned(mis3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return a ^ 32'h1234_0000;
    endfunction

    always @(posedge clk) begin
        p1 <= imem_en1 ? mem_word(imem_addr1) : 32'hDEAD_BEEF;
    end
    assign rdata1 = p1;

    always @(posedge clk) begin
        p3[0] <= imem_en3 ? mem_word(imem_addr3) : 32'hDEAD_BEEF;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign rdata3 = p3[2];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic fetch1(input logic bt, input logic [31:0] tgt,
                          input logic [31:0] e_addr, input logic [31:0] e_pc,
                          input logic [31:0] e_ins, input logic e_mis);
        int n;
        bit got;
        en1 = 1'b1;
        bt1 = bt;
        tgt1 = tgt;
        #1;
        chk("cmp_drop", {31'd0, completed1}, 32'd0);
        @(posedge clk);
        #1;
        en1 = 1'b0;
        bt1 = 1'b0;
        tgt1 = 32'h0;
        chk("imem_en", {31'd0, imem_en1}, 32'd1);
        chk("imem_addr", imem_addr1, e_addr);
        n = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            @(posedge clk);
            #1;
            n++;
            if (completed1) got = 1'b1;
        end
        chk("latency", n, 32'd2);
        chk("pc", pc1, e_pc);
        chk("instr", instr1, e_ins);
        chk("mis", {31'd0, mis1}, {31'd0, e_mis});
        chk("en_low", {31'd0, imem_en1}, 32'd0);
    endtask

    initial begin
        int n;
        bit got;
        rst1 = 1'b1; en1 = 1'b0; bt1 = 1'b0; tgt1 = 32'h0;
        rst3 = 1'b1; en3 = 1'b0; bt3 = 1'b0; tgt3 = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmp", {31'd0, completed1}, 32'd0);
        chk("rst_pc", pc1, 32'h0);
        chk("rst_instr", instr1, 32'h0000_0013);
        chk("rst_en", {31'd0, imem_en1}, 32'd0);
        chk("rst_addr", imem_addr1, 32'h0);
        chk("rst_mis", {31'd0, mis1}, 32'd0);
        rst1 = 1'b0;
        rst3 = 1'b0;

        fetch1(1'b0, 32'h0, 32'h0, 32'h0, 32'h0050_0093, 1'b0);
        fetch1(1'b0, 32'h0, 32'h4, 32'h4, 32'h1234_0004, 1'b0);
        fetch1(1'b0, 32'h0, 32'h8, 32'h8, 32'h1234_0008, 1'b0);
        fetch1(1'b1, 32'h40, 32'h40, 32'h40, 32'h1234_0040, 1'b0);
        fetch1(1'b0, 32'h0, 32'h44, 32'h44, 32'h1234_0044, 1'b0);
        fetch1(1'b1, 32'h42, 32'h40, 32'h42, 32'h0000_0013, 1'b1);
        fetch1(1'b0, 32'h0, 32'h44, 32'h46, 32'h0000_0013, 1'b1);
        fetch1(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FFFC,
               32'hEDCB_FFFC, 1'b0);
        fetch1(1'b0, 32'h0, 32'h0, 32'h0, 32'h0050_0093, 1'b0);

        en3 = 1'b1;
        @(posedge clk);
        #1;
        en3 = 1'b0;
        chk("l3_en", {31'd0, imem_en3}, 32'd1);
        chk("l3_addr", imem_addr3, 32'h0);
        @(posedge clk);
        #1;
        chk("l3_en_low", {31'd0, imem_en3}, 32'd0);
        en3 = 1'b1;
        bt3 = 1'b1;
        tgt3 = 32'h80;
        @(posedge clk);
        #1;
        chk("l3_ign_en", {31'd0, imem_en3}, 32'd0);
        chk("l3_ign_addr", imem_addr3, 32'h0);
        en3 = 1'b0;
        bt3 = 1'b0;
        tgt3 = 32'h0;
        @(posedge clk);
        #1;
        chk("l3_early", {31'd0, completed3}, 32'd0);
        @(posedge clk);
        #1;
        chk("l3_cmp", {31'd0, completed3}, 32'd1);
        chk("l3_pc", pc3, 32'h0);
        chk("l3_instr", instr3, 32'h0050_0093);

        en3 = 1'b1;
        @(posedge clk);
        #1;
        en3 = 1'b0;
        chk("l3_seq_addr", imem_addr3, 32'h4);
        repeat (2) @(posedge clk);
        #1;
        rst3 = 1'b1;
        @(posedge clk);
        #1;
        rst3 = 1'b0;
        chk("l3_rst_cmp", {31'd0, completed3}, 32'd0);
        chk("l3_rst_instr", instr3, 32'h0000_0013);
        chk("l3_rst_pc", pc3, 32'h0);
        chk("l3_rst_en", {31'd0, imem_en3}, 32'd0);
        got = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (completed3) got = 1'b1;
        end
        chk("l3_no_late", {31'd0, got}, 32'd0);

        en3 = 1'b1;
        @(posedge clk);
        #1;
        en3 = 1'b0;
        chk("l3_rpc_addr", imem_addr3, 32'h0);
        n = 0;
        got = 1'b0;
        while (!got && n < 10) begin
            @(posedge clk);
            #1;
            n++;
            if (completed3) got = 1'b1;
        end
        chk("l3_latency", n, 32'd4);
        chk("l3_rpc_pc", pc3, 32'h0);
        chk("l3_rpc_instr", instr3, 32'h0050_0093);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
